// File: rtl/qpu_exu_decode.sv
// QPU execution-unit instruction decoder: combinational field split and classification, one register stage to dispatch.
// Optional macro QPU_DEC_PRDT_EN forwards i_prdt_taken into the branch dec_info bit 6.
module qpu_exu_decode (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    input  logic        i_prdt_taken,
    output logic        dec_rs1x0,
    output logic        dec_rs2x0,
    output logic        dec_rs1en,
    output logic        dec_rs2en,
    output logic        dec_rdwen,
    output logic [4:0]  dec_rs1idx,
    output logic [4:0]  dec_rs2idx,
    output logic [4:0]  dec_rdidx,
    output logic [15:0] dec_info,
    output logic [31:0] dec_imm,
    output logic [31:0] dec_pc,
    output logic        dec_new_timepoint,
    output logic        dec_need_qubitflag,
    output logic        dec_measure,
    output logic        dec_fmr,
    output logic        dec_bxx,
    output logic [31:0] dec_bjp_imm
);

    localparam logic [1:0] GRP_ALU = 2'b00;
    localparam logic [1:0] GRP_BJP = 2'b01;
    localparam logic [1:0] GRP_LSU = 2'b10;
    localparam logic [1:0] GRP_QIU = 2'b11;

    logic        q_flag;
    logic [1:0]  maj;
    logic [1:0]  mnr;
    logic [2:0]  func;
    logic [4:0]  rs1_fld;
    logic [4:0]  rs2_fld;
    logic [4:0]  rd_fld;
    logic [2:0]  pre_intv;
    logic [8:0]  gate1;
    logic [8:0]  gate2;
    logic [31:0] imm_i;
    logic [31:0] imm_sb;
    logic [31:0] imm_q;

    assign q_flag   = i_instr[0];
    assign maj      = i_instr[2:1];
    assign mnr      = i_instr[4:3];
    assign func     = i_instr[31:29];
    assign rd_fld   = i_instr[9:5];
    assign rs1_fld  = i_instr[14:10];
    assign rs2_fld  = i_instr[28:24];
    assign pre_intv = i_instr[31:29];
    assign gate1    = i_instr[9:1];
    assign gate2    = i_instr[23:15];

    assign imm_i  = {{18{i_instr[28]}}, i_instr[28:24], i_instr[23:15]};
    assign imm_sb = {{18{i_instr[9]}},  i_instr[9:5],   i_instr[23:15]};
    assign imm_q  = {18'b0,             i_instr[14:10], i_instr[23:15]};

    logic        rs1en_nx;
    logic        rs2en_nx;
    logic        rdwen_nx;
    logic [15:0] info_nx;
    logic [31:0] imm_nx;
    logic [31:0] bjp_imm_nx;
    logic        ntp_nx;
    logic        nqf_nx;
    logic        meas_nx;
    logic        fmr_nx;
    logic        bxx_nx;
    logic        illegal;

`ifndef QPU_DEC_PRDT_EN
    logic unused_prdt;
    assign unused_prdt = i_prdt_taken;
`endif

    always_comb begin
        rs1en_nx   = 1'b0;
        rs2en_nx   = 1'b0;
        rdwen_nx   = 1'b0;
        info_nx    = 16'h0000;
        imm_nx     = 32'h0000_0000;
        bjp_imm_nx = 32'h0000_0000;
        ntp_nx     = 1'b0;
        nqf_nx     = 1'b0;
        meas_nx    = 1'b0;
        fmr_nx     = 1'b0;
        bxx_nx     = 1'b0;
        illegal    = 1'b0;

        if (q_flag) begin
            rs1en_nx     = 1'b1;
            rs2en_nx     = (gate2 != 9'd0);
            nqf_nx       = 1'b1;
            ntp_nx       = (pre_intv != 3'd0);
            meas_nx      = (gate1 == 9'h1FF);
            imm_nx       = {14'b0, gate2, gate1};
            info_nx[1:0] = GRP_QIU;
            info_nx[5]   = 1'b1;
            info_nx[6]   = meas_nx;
        end else begin
            case ({maj, mnr})
                4'b0000: begin // LOAD, func carries access size
                    rs1en_nx     = 1'b1;
                    rdwen_nx     = 1'b1;
                    imm_nx       = imm_i;
                    info_nx[1:0] = GRP_LSU;
                    info_nx[2]   = 1'b1;
                    info_nx[5:4] = func[1:0];
                end
                4'b0001: begin // STORE
                    rs1en_nx     = 1'b1;
                    rs2en_nx     = 1'b1;
                    imm_nx       = imm_sb;
                    info_nx[1:0] = GRP_LSU;
                    info_nx[3]   = 1'b1;
                    info_nx[5:4] = func[1:0];
                end
                4'b0011: begin
                    illegal      = func[2];
                    rs1en_nx     = 1'b1;
                    rs2en_nx     = 1'b1;
                    bxx_nx       = 1'b1;
                    bjp_imm_nx   = imm_sb;
                    info_nx[1:0] = GRP_BJP;
                    info_nx[5:2] = 4'b0001 << func[1:0];
`ifdef QPU_DEC_PRDT_EN
                    info_nx[6]   = i_prdt_taken;
`endif
                end
                4'b0100: begin // ALU with immediate operand
                    illegal      = func[2];
                    rs1en_nx     = 1'b1;
                    rdwen_nx     = 1'b1;
                    imm_nx       = imm_i;
                    info_nx[1:0] = GRP_ALU;
                    info_nx[5:2] = 4'b0001 << func[1:0];
                    info_nx[6]   = 1'b1;
                end
                4'b0101: begin
                    illegal      = func[2];
                    rs1en_nx     = 1'b1;
                    rs2en_nx     = 1'b1;
                    rdwen_nx     = 1'b1;
                    info_nx[1:0] = GRP_ALU;
                    info_nx[5:2] = 4'b0001 << func[1:0];
                end
                4'b0110: begin // QWAIT
                    imm_nx       = imm_q;
                    ntp_nx       = 1'b1;
                    info_nx[1:0] = GRP_QIU;
                    info_nx[2]   = 1'b1;
                end
                4'b0111: begin
                    rs1en_nx     = 1'b1;
                    rdwen_nx     = 1'b1;
                    fmr_nx       = 1'b1;
                    info_nx[1:0] = GRP_QIU;
                    info_nx[3]   = 1'b1;
                end
                4'b1100: begin // SMIS
                    rdwen_nx     = 1'b1;
                    imm_nx       = imm_q;
                    info_nx[1:0] = GRP_QIU;
                    info_nx[4]   = 1'b1;
                end
                4'b1000: begin // WFI only with every upper bit clear
                    if (i_instr[31:5] == 27'd0) begin
                        info_nx[1:0] = GRP_ALU;
                        info_nx[7]   = 1'b1;
                    end else begin
                        illegal = 1'b1;
                    end
                end
                default: illegal = 1'b1;
            endcase
        end

        if (illegal) begin
            rs1en_nx   = 1'b0;
            rs2en_nx   = 1'b0;
            rdwen_nx   = 1'b0;
            imm_nx     = 32'h0000_0000;
            bjp_imm_nx = 32'h0000_0000;
            ntp_nx     = 1'b0;
            nqf_nx     = 1'b0;
            meas_nx    = 1'b0;
            fmr_nx     = 1'b0;
            bxx_nx     = 1'b0;
            info_nx    = 16'h8000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_rs1x0          <= 1'b0;
            dec_rs2x0          <= 1'b0;
            dec_rs1en          <= 1'b0;
            dec_rs2en          <= 1'b0;
            dec_rdwen          <= 1'b0;
            dec_rs1idx         <= 5'd0;
            dec_rs2idx         <= 5'd0;
            dec_rdidx          <= 5'd0;
            dec_info           <= 16'h0000;
            dec_imm            <= 32'h0000_0000;
            dec_pc             <= 32'h0000_0000;
            dec_new_timepoint  <= 1'b0;
            dec_need_qubitflag <= 1'b0;
            dec_measure        <= 1'b0;
            dec_fmr            <= 1'b0;
            dec_bxx            <= 1'b0;
            dec_bjp_imm        <= 32'h0000_0000;
        end else begin
            dec_rs1x0          <= (rs1_fld == 5'd0);
            dec_rs2x0          <= (rs2_fld == 5'd0);
            dec_rs1en          <= rs1en_nx;
            dec_rs2en          <= rs2en_nx;
            dec_rdwen          <= rdwen_nx;
            dec_rs1idx         <= rs1_fld;
            dec_rs2idx         <= rs2_fld;
            dec_rdidx          <= rd_fld;
            dec_info           <= info_nx;
            dec_imm            <= imm_nx;
            dec_pc             <= i_pc;
            dec_new_timepoint  <= ntp_nx;
            dec_need_qubitflag <= nqf_nx;
            dec_measure        <= meas_nx;
            dec_fmr            <= fmr_nx;
            dec_bxx            <= bxx_nx;
            dec_bjp_imm        <= bjp_imm_nx;
        end
    end

endmodule

// File: tb/tb_qpu_exu_decode.sv
// Directed bench for qpu_exu_decode: expected decodes queued at drive time, popped one cycle later.
module tb_qpu_exu_decode;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] i_instr;
    logic [31:0] i_pc;
    logic        i_prdt_taken;
    logic        dec_rs1x0, dec_rs2x0, dec_rs1en, dec_rs2en, dec_rdwen;
    logic [4:0]  dec_rs1idx, dec_rs2idx, dec_rdidx;
    logic [15:0] dec_info;
    logic [31:0] dec_imm, dec_pc, dec_bjp_imm;
    logic        dec_new_timepoint, dec_need_qubitflag, dec_measure, dec_fmr, dec_bxx;

    qpu_exu_decode dut (
        .clk(clk), .rst_n(rst_n), .i_instr(i_instr), .i_pc(i_pc), .i_prdt_taken(i_prdt_taken),
        .dec_rs1x0(dec_rs1x0), .dec_rs2x0(dec_rs2x0), .dec_rs1en(dec_rs1en), .dec_rs2en(dec_rs2en),
        .dec_rdwen(dec_rdwen), .dec_rs1idx(dec_rs1idx), .dec_rs2idx(dec_rs2idx), .dec_rdidx(dec_rdidx),
        .dec_info(dec_info), .dec_imm(dec_imm), .dec_pc(dec_pc),
        .dec_new_timepoint(dec_new_timepoint), .dec_need_qubitflag(dec_need_qubitflag),
        .dec_measure(dec_measure), .dec_fmr(dec_fmr), .dec_bxx(dec_bxx), .dec_bjp_imm(dec_bjp_imm)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rs1x0, rs2x0, rs1en, rs2en, rdwen, ntp, nqf, meas, fmr, bxx;
        logic [4:0]  rs1, rs2, rd;
        logic [15:0] info;
        logic [31:0] imm, bjp, pc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] pc_ctr = 32'h0000_1000;
    logic [15:0] br_info [4]  = '{16'h0005, 16'h0009, 16'h0011, 16'h0021};
    logic [15:0] alu_info [4] = '{16'h0004, 16'h0008, 16'h0010, 16'h0020};

    function automatic logic [31:0] cls(logic [2:0] f, logic [4:0] rs2, logic [8:0] mid,
                                        logic [4:0] rs1, logic [4:0] rd, logic [1:0] mn, logic [1:0] mj);
        return {f, rs2, mid, rs1, rd, mn, mj, 1'b0};
    endfunction

    function automatic logic [31:0] qi(logic [2:0] pre, logic [4:0] rs2, logic [8:0] g2,
                                       logic [4:0] rs1, logic [8:0] g1);
        return {pre, rs2, g2, rs1, g1, 1'b1};
    endfunction

    function automatic exp_t base(logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd);
        exp_t e;
        e     = '0;
        e.rs1 = rs1;
        e.rs2 = rs2;
        e.rd  = rd;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compare(input string tag, input exp_t e);
        exp_t o;
        o = {dec_rs1x0, dec_rs2x0, dec_rs1en, dec_rs2en, dec_rdwen, dec_new_timepoint,
             dec_need_qubitflag, dec_measure, dec_fmr, dec_bxx, dec_rs1idx, dec_rs2idx,
             dec_rdidx, dec_info, dec_imm, dec_bjp_imm, dec_pc};
        check({tag, ".flags"}, 32'(o[$bits(exp_t)-1 -: 10]), 32'(e[$bits(exp_t)-1 -: 10]));
        check({tag, ".idx"},   32'({o.rs1, o.rs2, o.rd}), 32'({e.rs1, e.rs2, e.rd}));
        check({tag, ".info"},  32'(o.info), 32'(e.info));
        check({tag, ".imm"},   o.imm, e.imm);
        check({tag, ".bjp"},   o.bjp, e.bjp);
        check({tag, ".pc"},    o.pc, e.pc);
    endtask

    task automatic step(input string tag, input logic [31:0] instr, input logic prdt, input exp_t e_in);
        exp_t e;
        e       = e_in;
        e.rs1x0 = (e.rs1 == 5'd0);
        e.rs2x0 = (e.rs2 == 5'd0);
        e.pc    = pc_ctr;
        @(negedge clk);
        i_instr      = instr;
        i_pc         = pc_ctr;
        i_prdt_taken = prdt;
        sb.push_back(e);
        pc_ctr = pc_ctr + 32'd4;
        @(posedge clk);
        #1;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL %s scoreboard observed=empty expected=entry", tag);
        end else begin
            compare(tag, sb.pop_front());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst_n        = 1'b0;
        i_instr      = 32'h55AA_A640;
        i_pc         = 32'hDEAD_BEEF;
        i_prdt_taken = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        compare("reset", '0);
        @(negedge clk);
        rst_n = 1'b1;

        e = base(9, 21, 18); e.rs1en = 1; e.rdwen = 1; e.imm = 32'hFFFF_EB55; e.info = 16'h0026;
        step("load", 32'h55AA_A640, 1'b0, e);

        e = base(9, 10, 3); e.rs1en = 1; e.rs2en = 1; e.imm = 32'h0000_06F0; e.info = 16'h001A;
        step("store", cls(3'b001, 5'd10, 9'h0F0, 5'd9, 5'd3, 2'b01, 2'b00), 1'b0, e);

        for (int f = 0; f < 4; f++) begin
            e = base(9, 10, 21); e.rs1en = 1; e.rs2en = 1; e.bxx = 1;
            e.bjp = 32'hFFFF_EB55; e.info = br_info[f];
`ifdef QPU_DEC_PRDT_EN
            if (f == 1) e.info[6] = 1'b1;
`endif
            step("branch", cls(3'(f), 5'd10, 9'h155, 5'd9, 5'd21, 2'b11, 2'b00), (f == 1), e);
        end

        for (int f = 0; f < 4; f++) begin
            e = base(9, 10, 18); e.rs1en = 1; e.rs2en = 1; e.rdwen = 1; e.info = alu_info[f];
            step("alu_reg", cls(3'(f), 5'd10, 9'h155, 5'd9, 5'd18, 2'b01, 2'b01), 1'b0, e);
        end

        e = base(9, 10, 18); e.rs1en = 1; e.rdwen = 1; e.imm = 32'h0000_1555; e.info = 16'h0044;
        step("addi", cls(3'b000, 5'd10, 9'h155, 5'd9, 5'd18, 2'b00, 2'b01), 1'b0, e);

        e = base(9, 26, 18); e.rs1en = 1; e.rdwen = 1; e.imm = 32'hFFFF_F401; e.info = 16'h0060;
        step("andi", cls(3'b011, 5'd26, 9'h001, 5'd9, 5'd18, 2'b00, 2'b01), 1'b0, e);

        e = base(9, 10, 18); e.info = 16'h8000;
        step("alu_f4", cls(3'b100, 5'd10, 9'h000, 5'd9, 5'd18, 2'b01, 2'b01), 1'b0, e);

        e = base(31, 0, 0); e.ntp = 1; e.imm = 32'h0000_3FFF; e.info = 16'h0007;
        step("qwait", cls(3'b000, 5'd0, 9'h1FF, 5'd31, 5'd0, 2'b10, 2'b01), 1'b0, e);

        e = base(9, 0, 18); e.rs1en = 1; e.rdwen = 1; e.fmr = 1; e.info = 16'h000B;
        step("fmr", cls(3'b010, 5'd0, 9'h000, 5'd9, 5'd18, 2'b11, 2'b01), 1'b0, e);

        e = base(7, 0, 3); e.rdwen = 1; e.imm = 32'h0000_0EAB; e.info = 16'h0013;
        step("smis", cls(3'b000, 5'd0, 9'h0AB, 5'd7, 5'd3, 2'b00, 2'b11), 1'b0, e);

        e = base(0, 0, 0); e.info = 16'h0080;
        step("wfi", 32'h0000_0004, 1'b0, e);

        e = base(0, 0, 1); e.info = 16'h8000;
        step("wfi_bad", 32'h0000_0024, 1'b0, e);

        e = base(1, 1, 1); e.info = 16'h8000;
        step("maj0_m2", cls(3'b000, 5'd1, 9'h000, 5'd1, 5'd1, 2'b10, 2'b00), 1'b0, e);

        e = base(31, 31, 31); e.info = 16'h8000;
        step("illegal", 32'hFFFF_FFF8, 1'b1, e);

        e = base(9, 10, 30); e.rs1en = 1; e.rs2en = 1; e.ntp = 1; e.nqf = 1;
        e.imm = 32'h0000_3DE1; e.info = 16'h0023;
        step("qi", qi(3'b111, 5'd10, 9'h01E, 5'd9, 9'h1E1), 1'b1, e);

        e = base(9, 0, 31); e.rs1en = 1; e.ntp = 1; e.nqf = 1; e.meas = 1;
        e.imm = 32'h0000_01FF; e.info = 16'h0063;
        step("measure", qi(3'b011, 5'd0, 9'h000, 5'd9, 9'h1FF), 1'b0, e);

        e = base(0, 3, 0); e.rs1en = 1; e.rs2en = 1; e.nqf = 1;
        e.imm = 32'h0000_0A02; e.info = 16'h0023;
        step("qi_pre0", qi(3'b000, 5'd3, 9'h005, 5'd0, 9'h002), 1'b0, e);

        // Asynchronous clear mid-stream: outputs must drop before any clock edge.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        compare("rst_async", '0);
        i_instr = 32'h55AA_A640;
        @(posedge clk);
        #1;
        compare("rst_hold", '0);
        @(negedge clk);
        rst_n = 1'b1;

        e = base(9, 21, 18); e.rs1en = 1; e.rdwen = 1; e.imm = 32'hFFFF_EB55; e.info = 16'h0026;
        step("load_after_rst", 32'h55AA_A640, 1'b0, e);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
